// File: rtl/capture_arbiter_if.sv
// Bus bundle between the capture bank, the arbiter and the downstream decoder.
// CAPTURE_ARB_DROP_CNT_EN adds the drop_count field.
interface capture_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 32
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       ch_ready;
  logic [N*WIDTH-1:0] ch_center;
  logic [N-1:0]       ch_clr;
  logic [WIDTH-1:0]   out_data;
  logic [CW-1:0]      out_chan;
  logic               out_valid;
  logic               out_ack;
  logic               overflow;
  logic               ovf_clr;
`ifdef CAPTURE_ARB_DROP_CNT_EN
  logic [15:0]        drop_count;

  modport master (
    input  ch_ready, ch_center, out_ack, ovf_clr,
    output ch_clr, out_data, out_chan, out_valid, overflow, drop_count
  );
  modport slave (
    output ch_ready, ch_center, out_ack, ovf_clr,
    input  ch_clr, out_data, out_chan, out_valid, overflow, drop_count
  );
`else
  modport master (
    input  ch_ready, ch_center, out_ack, ovf_clr,
    output ch_clr, out_data, out_chan, out_valid, overflow
  );
  modport slave (
    output ch_ready, ch_center, out_ack, ovf_clr,
    input  ch_clr, out_data, out_chan, out_valid, overflow
  );
`endif
endinterface

// File: rtl/capture_arbiter.sv
// Round-robin drain of N capture channels into a tagged first-word-fall-through FIFO.
// Optional drop counter enabled by CAPTURE_ARB_DROP_CNT_EN.
module capture_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  capture_arbiter_if.master  bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {SCAN, CLEAR, SETTLE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    rr_q, rr_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] center_q, center_d;
  logic [N-1:0]     clr_q, clr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
`ifdef CAPTURE_ARB_DROP_CNT_EN
  logic [15:0]      drop_cnt_q, drop_cnt_d;
`endif

  logic [CW+WIDTH-1:0] mem_q [DEPTH];
  logic [CW+WIDTH-1:0] head;

  logic          found;
  logic [CW-1:0] hit;
  logic [CW-1:0] hit_next;
  logic          push, pop, wr_en, drop, empty, full;

  // First ready channel at or after the round-robin pointer, wrapping at N-1.
  always_comb begin
    int j;
    found = 1'b0;
    hit   = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_q) + k;
      if (j >= N) j = j - N;
      if (!found && bus.ch_ready[j]) begin
        found = 1'b1;
        hit   = CW'(j);
      end
    end
    if (int'(hit) == N - 1) hit_next = '0;
    else                    hit_next = hit + CW'(1);
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    idx_d    = idx_q;
    center_d = center_q;
    clr_d    = '0;
    push     = 1'b0;
    case (state_q)
      SCAN: begin
        if (found) begin
          idx_d      = hit;
          center_d   = bus.ch_center[hit*WIDTH +: WIDTH];
          rr_d       = hit_next;
          clr_d[hit] = 1'b1;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        push    = 1'b1;
        state_d = SETTLE;
      end
      SETTLE:  state_d = SCAN;
      default: state_d = SCAN;
    endcase
  end

  // Pointer MSB separates full from empty; a pop in the same cycle frees room for a push at full.
  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = !empty && bus.out_ack;
    wr_en      = push && (!full || pop);
    drop       = push && !wr_en;
    wr_ptr_d   = wr_ptr_q + PW'(wr_en);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    overflow_d = overflow_q;
    if (drop)             overflow_d = 1'b1;
    else if (bus.ovf_clr) overflow_d = 1'b0;
  end

`ifdef CAPTURE_ARB_DROP_CNT_EN
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.ovf_clr)                 drop_cnt_d = drop ? 16'd1 : 16'd0;
    else if (drop && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + 16'd1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SCAN;
      rr_q       <= '0;
      idx_q      <= '0;
      center_q   <= '0;
      clr_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
`ifdef CAPTURE_ARB_DROP_CNT_EN
      drop_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      idx_q      <= idx_d;
      center_q   <= center_d;
      clr_q      <= clr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
`ifdef CAPTURE_ARB_DROP_CNT_EN
      drop_cnt_q <= drop_cnt_d;
`endif
    end
  end

  // Storage carries no reset; reset only empties it through the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {idx_q, center_q};
  end

  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.ch_clr    = clr_q;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : head[WIDTH-1:0];
  assign bus.out_chan  = empty ? '0 : head[WIDTH +: CW];
  assign bus.overflow  = overflow_q;
`ifdef CAPTURE_ARB_DROP_CNT_EN
  assign bus.drop_count = drop_cnt_q;
`endif
endmodule

// File: tb/tb_capture_arbiter.sv
// Scoreboard bench for capture_arbiter: directed stimulus, FIFO pops checked by a monitor.
// Exercises drop_count checks when CAPTURE_ARB_DROP_CNT_EN is defined.
module tb_capture_arbiter;
  localparam int N     = 4;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  typedef struct {
    logic [1:0]  chan;
    logic [31:0] data;
  } ent_t;

  logic clk;
  logic rst;

  capture_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus();

  capture_arbiter #(.N(N), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  ent_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          pops  = 0;
  logic [31:0] cen [N];
  logic [3:0]  pend;
  logic [3:0]  rearm;
  logic [3:0]  s_clr;
  logic        s_valid;
  logic [1:0]  s_chan;
  logic [31:0] s_data;
  logic        s_ovf;
`ifdef CAPTURE_ARB_DROP_CNT_EN
  logic [15:0] s_drop;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: every accepted pop must match the oldest expected entry.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ack) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL fifo_head: got chan=%0d data=%h with nothing expected", bus.out_chan, bus.out_data);
        end else begin
          e = exp_q.pop_front();
          pops++;
          if (bus.out_chan !== e.chan || bus.out_data !== e.data) begin
            bad++;
            $display("FAIL fifo_head: got chan=%0d data=%h want chan=%0d data=%h",
                     bus.out_chan, bus.out_data, e.chan, e.data);
          end else begin
            $display("pop chan=%0d data=%h", bus.out_chan, bus.out_data);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Snapshot one cycle at its negedge, then step to just after the next posedge.
  // A channel drops its ready the cycle after its clr pulse unless re-armed.
  task automatic tick();
    @(negedge clk);
    s_clr   = bus.ch_clr;
    s_valid = bus.out_valid;
    s_chan  = bus.out_chan;
    s_data  = bus.out_data;
    s_ovf   = bus.overflow;
`ifdef CAPTURE_ARB_DROP_CNT_EN
    s_drop  = bus.drop_count;
`endif
    pend = bus.ch_clr;
    @(posedge clk);
    #1;
    bus.ch_ready = (bus.ch_ready & ~pend) | (pend & rearm);
  endtask

  task automatic set_center(input int ch, input logic [31:0] val);
    cen[ch] = val;
    bus.ch_center[ch*WIDTH +: WIDTH] = val;
  endtask

  task automatic push_exp(input logic [1:0] ch, input logic [31:0] val);
    ent_t e;
    e.chan = ch;
    e.data = val;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.ch_ready = '0;
    bus.out_ack  = 1'b0;
    bus.ovf_clr  = 1'b0;
    rearm        = '0;
    exp_q.delete();
    tick();
    tick();
    chk("rst_clr", s_clr, 0);
    chk("rst_valid", s_valid, 0);
    chk("rst_chan", s_chan, 0);
    chk("rst_data", s_data, 0);
    chk("rst_ovf", s_ovf, 0);
    rst = 1'b0;
  endtask

  task automatic drain(input int cycles);
    bus.out_ack = 1'b1;
    repeat (cycles) tick();
    chk("drain_left", exp_q.size(), 0);
    chk("drain_valid", s_valid, 0);
    bus.out_ack = 1'b0;
  endtask

  // All four channels ready from a fresh reset: grant g goes to channel g%4, clr at cycle 3g+1.
  task automatic fill_all(input int grants, input logic ack);
    int         drops;
    int         ch;
    logic [3:0] one;
    logic [3:0] e;
    drops        = 0;
    one          = 4'b0001;
    bus.out_ack  = ack;
    bus.ch_ready = 4'hF;
    rearm        = 4'hF;
    for (int c = 0; c < 3 * grants; c++) begin
      tick();
      e = (c % 3 == 1) ? (one << ((c / 3) % 4)) : 4'b0000;
      chk("grant_clr", s_clr, e);
      chk("grant_ovf", s_ovf, (drops > 0));
`ifdef CAPTURE_ARB_DROP_CNT_EN
      chk("grant_drops", s_drop, drops);
`endif
      if (s_clr != 0) begin
        ch = (c / 3) % 4;
        if (ack || exp_q.size() < DEPTH) push_exp(2'(ch), cen[ch]);
        else drops++;
        set_center(ch, cen[ch] + 32'h100);
      end
    end
    bus.ch_ready = '0;
    rearm        = '0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.ch_ready  = '0;
    bus.ch_center = '0;
    bus.out_ack   = 1'b0;
    bus.ovf_clr   = 1'b0;
    rearm         = '0;
    pend          = '0;
    for (int i = 0; i < N; i++) set_center(i, 32'hC000_0000 + 32'(i));

    // Single channel 2
    do_reset();
    set_center(2, 32'h1234);
    bus.ch_ready = 4'b0100;
    push_exp(2'd2, 32'h1234);
    tick();
    chk("single_scan_clr", s_clr, 4'b0000);
    tick();
    chk("single_clr", s_clr, 4'b0100);
    chk("single_clr_valid", s_valid, 0);
    tick();
    chk("single_settle_clr", s_clr, 4'b0000);
    chk("single_valid", s_valid, 1);
    chk("single_chan", s_chan, 2);
    chk("single_data", s_data, 32'h1234);
    tick();
    chk("single_hold", s_valid, 1);
    chk("single_no_regrant", s_clr, 4'b0000);
    bus.out_ack = 1'b1;
    tick();
    tick();
    chk("single_one_entry", s_valid, 0);
    chk("single_left", exp_q.size(), 0);
    bus.out_ack = 1'b0;
    $display("single channel done");

    // Fairness with all channels ready and a free-running consumer
    do_reset();
    for (int i = 0; i < N; i++) set_center(i, 32'hA000_0000 + 32'(i));
    fill_all(6, 1'b1);
    drain(6);
    $display("fairness done");

    // Fill to DEPTH, drop the ninth, then clear the sticky flag
    do_reset();
    for (int i = 0; i < N; i++) set_center(i, 32'hC000_0000 + 32'(i));
    fill_all(9, 1'b0);
    chk("full_ovf", s_ovf, 1);
    chk("full_left", exp_q.size(), DEPTH);
    bus.ovf_clr = 1'b1;
    tick();
    chk("ovf_clr_cycle", s_ovf, 1);
    bus.ovf_clr = 1'b0;
    tick();
    chk("ovf_cleared", s_ovf, 0);
    $display("overflow done");

    // Push and pop together while full
    pops = 0;
    bus.ch_ready = 4'b0010;
    push_exp(2'd1, cen[1]);
    tick();
    chk("pp_scan_clr", s_clr, 4'b0000);
    bus.out_ack = 1'b1;
    tick();
    chk("pp_clr", s_clr, 4'b0010);
    bus.out_ack = 1'b0;
    tick();
    chk("pp_no_drop", s_ovf, 0);
    chk("pp_head_chan", s_chan, 1);
    chk("pp_head_data", s_data, 32'hC000_0001);
    drain(14);
    chk("pp_occupancy", pops, DEPTH + 1);
    $display("push+pop at full done");

    // Asynchronous reset during the clr pulse
    do_reset();
    for (int i = 0; i < N; i++) set_center(i, 32'hC000_0000 + 32'(i));
    fill_all(9, 1'b0);
    bus.ch_ready = 4'b0010;
    tick();
    chk("ar_pre_clr", bus.ch_clr, 4'b0010);
    rst = 1'b1;
    #1;
    chk("ar_clr", bus.ch_clr, 4'b0000);
    chk("ar_valid", bus.out_valid, 0);
    chk("ar_ovf", bus.overflow, 0);
    exp_q.delete();
    bus.ch_ready = 4'b1000;
    set_center(3, 32'hBEEF_0003);
    tick();
    tick();
    rst = 1'b0;
    push_exp(2'd3, 32'hBEEF_0003);
    tick();
    chk("ar_first_scan", s_clr, 4'b0000);
    tick();
    chk("ar_grant", s_clr, 4'b1000);
    drain(6);
    $display("async reset done");

`ifdef CAPTURE_ARB_DROP_CNT_EN
    // Twenty drops, then a drop coinciding with ovf_clr
    do_reset();
    for (int i = 0; i < N; i++) set_center(i, 32'hD000_0000 + 32'(i));
    fill_all(DEPTH + 20, 1'b0);
    chk("dc_twenty", s_drop, 20);
    chk("dc_ovf", s_ovf, 1);
    bus.ch_ready = 4'b0001;
    tick();
    bus.ovf_clr = 1'b1;
    tick();
    chk("dc_clr_cycle", s_clr, 4'b0001);
    bus.ovf_clr = 1'b0;
    tick();
    chk("dc_coincide_cnt", s_drop, 1);
    chk("dc_coincide_ovf", s_ovf, 1);
    drain(30);
    $display("drop counter done");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
